// File: rtl/prog_mem_pkg.sv
// prog_mem_pkg: loader FSM states, default geometry and parity helper shared by the program memory.
package prog_mem_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
   localparam int DEF_DATA_W = 14;
   localparam int DEF_DEPTH = 2048;
   localparam logic [DEF_DATA_W-1:0] DEF_NOP_WORD = 14'h0000;
   // even-parity bit: storing it alongside the data makes the XOR of the whole word zero
   function automatic logic even_par(input logic [31:0] d);
      return ^d;
   endfunction
endpackage

// File: rtl/prog_mem_array.sv
// prog_mem_array: single write port, single registered read port storage; contents are never reset.
module prog_mem_array #(
   parameter int W = 14,
   parameter int DEPTH = 2048,
   parameter int AW = 11
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [W-1:0]  o_rdata
);
   logic [W-1:0] r_mem [DEPTH];
   logic [W-1:0] r_rdata;
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_raddr];
   end
   assign o_rdata = r_rdata;
endmodule

// File: rtl/prog_mem_ldr.sv
// prog_mem_ldr: run-time loadable program memory with 1-cycle fetch port and streaming loader.
// Define PROG_MEM_PARITY_EN to store and check an even-parity bit per word.
module prog_mem_ldr import prog_mem_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH = DEF_DEPTH,
   parameter int ADDR_W = 11,
   parameter logic [DATA_W-1:0] NOP_WORD = DEF_NOP_WORD
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_fetch_req,
   input  logic [ADDR_W-1:0] i_fetch_addr,
   output logic              o_fetch_valid,
   output logic [DATA_W-1:0] o_fetch_data,
   output logic              o_busy,
   input  logic              i_ld_start,
   input  logic              i_ld_valid,
   input  logic              i_ld_last,
   input  logic [DATA_W-1:0] i_ld_data,
   output logic              o_ld_ready,
   output logic              o_ld_done,
   output logic [ADDR_W:0]   o_ld_count,
   output logic              o_parity_err
);
`ifdef PROG_MEM_PARITY_EN
   localparam int MW = DATA_W + 1;
`else
   localparam int MW = DATA_W;
`endif
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] C_LAST = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);
   state_t r_state, w_next;
   logic [ADDR_W:0] r_ld_count;
   logic r_valid, r_hit;
   logic w_start, w_beat, w_accept, w_hit;
   logic [MW-1:0] w_wdata, w_rdata;
   assign w_start = r_state == IDLE && i_ld_start;
   assign w_beat = r_state == LOAD && i_ld_valid;
   assign w_accept = r_state == IDLE && i_fetch_req && !i_ld_start;
   assign w_hit = {1'b0, i_fetch_addr} < r_ld_count;
   always_comb begin
      w_next = r_state;
      w_next = w_start ? LOAD
             : (w_beat && (i_ld_last || r_ld_count == C_LAST)) ? DONE
             : r_state == DONE ? IDLE
             : r_state;
   end
   // ld_count doubles as the write pointer; the load ends before it can pass DEPTH
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= IDLE;
         r_ld_count <= '0;
         r_valid <= 1'b0;
         r_hit <= 1'b0;
      end else begin
         r_state <= w_next;
         r_valid <= w_accept;
         if (w_accept) r_hit <= w_hit;
         if (w_start) r_ld_count <= '0;
         else if (w_beat && r_ld_count != C_DEPTH) r_ld_count <= r_ld_count + 1'b1;
      end
`ifdef PROG_MEM_PARITY_EN
   assign w_wdata = {even_par(32'(i_ld_data)), i_ld_data};
   assign o_parity_err = r_valid && r_hit && ^w_rdata;
`else
   assign w_wdata = i_ld_data;
   assign o_parity_err = 1'b0;
`endif
   prog_mem_array #(.W(MW), .DEPTH(DEPTH), .AW(AW)) u_arr (
      .clk     (clk),
      .i_we    (w_beat),
      .i_waddr (r_ld_count[AW-1:0]),
      .i_wdata (w_wdata),
      .i_re    (w_accept),
      .i_raddr (i_fetch_addr[AW-1:0]),
      .o_rdata (w_rdata)
   );
   assign o_fetch_valid = r_valid;
   assign o_fetch_data = r_hit ? w_rdata[DATA_W-1:0] : NOP_WORD;
   assign o_busy = r_state != IDLE;
   assign o_ld_ready = r_state == LOAD;
   assign o_ld_done = r_state == DONE;
   assign o_ld_count = r_ld_count;
endmodule

// File: tb/tb_prog_mem_ldr.sv
// tb_prog_mem_ldr: directed checks of loading, fetching, drop rules and reset for a DEPTH=16 build.
module tb_prog_mem_ldr;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic fetch_req = 1'b0, ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
   logic [4:0] fetch_addr = '0;
   logic [13:0] ld_data = '0;
   logic fetch_valid, busy, ld_ready, ld_done, parity_err;
   logic [13:0] fetch_data;
   logic [5:0] ld_count;
   int n_run = 0, n_fail = 0, pulses = 0;

   always #5 clk = ~clk;
   always @(posedge clk) if (ld_done) pulses++;

   prog_mem_ldr #(.DATA_W(14), .DEPTH(16), .ADDR_W(5), .NOP_WORD(14'h0000)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .i_fetch_req(fetch_req), .i_fetch_addr(fetch_addr),
      .o_fetch_valid(fetch_valid), .o_fetch_data(fetch_data), .o_busy(busy),
      .i_ld_start(ld_start), .i_ld_valid(ld_valid), .i_ld_last(ld_last), .i_ld_data(ld_data),
      .o_ld_ready(ld_ready), .o_ld_done(ld_done), .o_ld_count(ld_count), .o_parity_err(parity_err)
   );

   typedef struct {
      logic req;
      logic [4:0] addr;
      logic exp_valid;
      logic [13:0] exp_data;
   } vec_t;
   vec_t vecs[12];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fetch(input logic [4:0] a, input logic [13:0] exp, input string name);
      fetch_req = 1'b1;
      fetch_addr = a;
      tick();
      fetch_req = 1'b0;
      chk({name, "_valid"}, 32'(fetch_valid), 32'd1);
      chk({name, "_data"}, 32'(fetch_data), 32'(exp));
   endtask

   task automatic start_load();
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
   endtask

   task automatic beat(input logic [13:0] d, input logic last);
      ld_valid = 1'b1;
      ld_data = d;
      ld_last = last;
      tick();
      ld_valid = 1'b0;
      ld_last = 1'b0;
   endtask

   initial begin
      logic [13:0] img [8];
      int p0;
      img[0] = 14'h3044;
      for (int i = 1; i < 8; i++) img[i] = 14'h3E00 + 14'(i);
      for (int i = 0; i < 8; i++) vecs[i] = '{1'b1, 5'(i), 1'b1, img[i]};
      vecs[8] = '{1'b0, 5'd3, 1'b0, 14'h3E07};
      vecs[9] = '{1'b1, 5'd8, 1'b1, 14'h0000};
      vecs[10] = '{1'b1, 5'd20, 1'b1, 14'h0000};
      vecs[11] = '{1'b1, 5'd4, 1'b1, 14'h3E04};

      #12;
      chk("rst_valid", 32'(fetch_valid), 32'd0);
      chk("rst_data", 32'(fetch_data), 32'h0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(ld_ready), 32'd0);
      chk("rst_done", 32'(ld_done), 32'd0);
      chk("rst_count", 32'(ld_count), 32'd0);
      chk("rst_perr", 32'(parity_err), 32'd0);
      rst_n = 1'b1;
      tick();
      fetch(5'd0, 14'h0000, "empty_fetch");

      start_load();
      chk("load_busy", 32'(busy), 32'd1);
      chk("load_ready", 32'(ld_ready), 32'd1);
      p0 = pulses;
      for (int i = 0; i < 8; i++) beat(img[i], i == 7);
      chk("load8_done", 32'(ld_done), 32'd1);
      chk("load8_count", 32'(ld_count), 32'd8);
      tick();
      chk("load8_idle", 32'(busy), 32'd0);
      chk("load8_pulses", 32'(pulses - p0), 32'd1);

      foreach (vecs[i]) begin
         fetch_req = vecs[i].req;
         fetch_addr = vecs[i].addr;
         tick();
         chk($sformatf("vec%0d_valid", i), 32'(fetch_valid), 32'(vecs[i].exp_valid));
         chk($sformatf("vec%0d_data", i), 32'(fetch_data), 32'(vecs[i].exp_data));
      end
      fetch_req = 1'b0;
      tick();

      fetch_req = 1'b1;
      fetch_addr = 5'd0;
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      chk("start_drop_valid", 32'(fetch_valid), 32'd0);
      chk("start_busy", 32'(busy), 32'd1);
      ld_valid = 1'b1;
      ld_data = 14'h0AAA;
      tick();
      chk("load_drop_valid", 32'(fetch_valid), 32'd0);
      chk("load_cnt1", 32'(ld_count), 32'd1);
      ld_start = 1'b1;
      ld_data = 14'h0BBB;
      tick();
      ld_start = 1'b0;
      chk("restart_ignored_cnt", 32'(ld_count), 32'd2);
      chk("restart_state", 32'(ld_ready), 32'd1);
      ld_data = 14'h0CCC;
      ld_last = 1'b1;
      tick();
      chk("done_drop_valid0", 32'(fetch_valid), 32'd0);
      chk("load3_count", 32'(ld_count), 32'd3);
      ld_valid = 1'b0;
      ld_last = 1'b0;
      tick();
      chk("done_drop_valid1", 32'(fetch_valid), 32'd0);
      fetch_req = 1'b0;
      fetch(5'd2, 14'h0CCC, "load3_a2");
      fetch(5'd3, 14'h0000, "load3_a3");

      start_load();
      ld_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         ld_data = 14'h1000 + 14'(i);
         tick();
      end
      chk("auto_done", 32'(ld_done), 32'd1);
      chk("auto_count", 32'(ld_count), 32'd16);
      tick();
      chk("auto_ready_low", 32'(ld_ready), 32'd0);
      tick();
      ld_valid = 1'b0;
      chk("extra_count", 32'(ld_count), 32'd16);
      chk("extra_idle", 32'(busy), 32'd0);
      fetch(5'd15, 14'h100F, "auto_a15");
      fetch(5'd16, 14'h0000, "auto_a16");

      start_load();
      for (int i = 0; i < 3; i++) beat(14'h2000 + 14'(i), 1'b0);
      chk("mid_count", 32'(ld_count), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_count", 32'(ld_count), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_valid", 32'(fetch_valid), 32'd0);
      #3 rst_n = 1'b1;
      tick();
      fetch(5'd1, 14'h0000, "mid_rst_a1");

      start_load();
      beat(14'h3E05, 1'b1);
      tick();
      fetch(5'd0, 14'h3E05, "par_clean");
      chk("par_clean_err", 32'(parity_err), 32'd0);
`ifdef PROG_MEM_PARITY_EN
      u_dut.u_arr.r_mem[0][0] = ~u_dut.u_arr.r_mem[0][0];
      fetch(5'd0, 14'h3E04, "par_flip");
      chk("par_flip_err", 32'(parity_err), 32'd1);
`else
      fetch(5'd0, 14'h3E05, "par_off");
      chk("par_off_err", 32'(parity_err), 32'd0);
`endif
      fetch(5'd9, 14'h0000, "par_nop");
      chk("par_nop_err", 32'(parity_err), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
